// File: rtl/bcdx_pkg.sv
// Shared constants and state encoding for the BCD <-> excess-3 converter.
package bcdx_pkg;
    localparam int         DIGIT_W      = 4;
    localparam logic [3:0] XS3_OFFSET   = 4'd3;
    localparam logic       MODE_BCD2XS3 = 1'b0;
    localparam logic       MODE_XS32BCD = 1'b1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;
endpackage

// File: rtl/bcdx_digit_conv.sv
// Combinational single-digit BCD <-> XS3 converter.
// With BCDX_ERR_DETECT_EN defined, out-of-range digits give 4'hF and invalid=1.
module bcdx_digit_conv
    import bcdx_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    input  logic               mode,
    output logic [DIGIT_W-1:0] q,
    output logic               invalid
);
    always_comb begin
        q = (mode == MODE_XS32BCD) ? d - XS3_OFFSET : d + XS3_OFFSET;
`ifdef BCDX_ERR_DETECT_EN
        if (mode == MODE_XS32BCD) invalid = (d < 4'd3) || (d > 4'd12);
        else                      invalid = (d > 4'd9);
        if (invalid) q = 4'hF;
`else
        invalid = 1'b0;
`endif
    end
endmodule

// File: rtl/bcd_xs3_conv_seq.sv
// Multi-digit BCD <-> XS3 converter, one digit per cycle through a shared datapath.
// Optional per-digit range checking is enabled by defining BCDX_ERR_DETECT_EN.
module bcd_xs3_conv_seq
    import bcdx_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic [NDIG*DIGIT_W-1:0] din,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NDIG*DIGIT_W-1:0] dout,
    output logic [NDIG-1:0]         err_mask
);
    localparam int W  = NDIG * DIGIT_W;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   din_q, din_d;
    logic           mode_q, mode_d;
    logic [W-1:0]   res_q, res_d;
    logic [DIGIT_W-1:0] dig_in, dig_out;
    logic           dig_inv;

    assign dig_in = din_q[cnt_q*DIGIT_W +: DIGIT_W];

    bcdx_digit_conv u_digit (
        .d       (dig_in),
        .mode    (mode_q),
        .q       (dig_out),
        .invalid (dig_inv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            din_q   <= '0;
            mode_q  <= MODE_BCD2XS3;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CONV;
            CONV:    if (cnt_q == CW'(NDIG - 1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on accept, then write one converted digit per CONV cycle.
    always_comb begin
        cnt_d  = cnt_q;
        din_d  = din_q;
        mode_d = mode_q;
        res_d  = res_q;
        if (state_q == IDLE && in_valid) begin
            din_d  = din;
            mode_d = mode;
            cnt_d  = '0;
        end else if (state_q == CONV) begin
            res_d[cnt_q*DIGIT_W +: DIGIT_W] = dig_out;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        dout      = res_q;
    end

`ifdef BCDX_ERR_DETECT_EN
    logic [NDIG-1:0] err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end

    always_comb begin
        err_d = err_q;
        if (state_q == CONV) err_d[cnt_q] = dig_inv;
    end

    assign err_mask = err_q;
`else
    logic unused_inv;
    assign unused_inv = dig_inv;
    assign err_mask   = '0;
`endif
endmodule

// File: tb/tb_bcd_xs3_conv_seq.sv
// Scoreboard bench for bcd_xs3_conv_seq: random words against an arithmetic reference model.
module tb_bcd_xs3_conv_seq;
    localparam int N = 4;

    typedef struct {
        logic [4*N-1:0] dout;
        logic [N-1:0]   err;
        int             acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [4*N-1:0] din = '0;
    logic in_ready, out_valid;
    logic [4*N-1:0] dout;
    logic [N-1:0] err_mask;

    logic in_valid1 = 1'b0, mode1 = 1'b0, out_ready1 = 1'b1;
    logic [3:0] din1 = '0;
    logic in_ready1, out_valid1;
    logic [3:0] dout1;
    logic [0:0] err_mask1;

    int tests = 0, fails = 0, cyc = 0;
    bit rr_en = 1'b1, forced_ready = 1'b1;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_xs3_conv_seq #(.NDIG(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .err_mask(err_mask)
    );

    bcd_xs3_conv_seq #(.NDIG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .mode(mode1),
        .din(din1), .out_valid(out_valid1), .out_ready(out_ready1), .dout(dout1), .err_mask(err_mask1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: add or subtract 3 per digit in plain integer arithmetic.
    function automatic exp_t model(input logic m, input logic [4*N-1:0] x);
        exp_t e;
        e.dout = '0; e.err = '0; e.acc = 0;
        for (int i = 0; i < N; i++) begin
            int d, r;
            bit ok;
            d = int'(x[4*i +: 4]);
            if (!m) begin ok = (d <= 9);           r = (d + 3) % 16;  end
            else    begin ok = (d >= 3 && d <= 12); r = (d + 13) % 16; end
`ifdef BCDX_ERR_DETECT_EN
            if (!ok) begin r = 15; e.err[i] = 1'b1; end
`else
            if (!ok) r = r;
`endif
            e.dout[4*i +: 4] = 4'(r);
        end
        return e;
    endfunction

    task automatic send(input logic m, input logic [4*N-1:0] x);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; mode = m; din = x;
        @(posedge clk); #1;
        e = model(m, x);
        e.acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        mode = $urandom_range(0, 1); din = 16'($urandom);
    endtask

    // Monitor: drives out_ready and checks each new result against the scoreboard.
    initial begin
        bit pv = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !pv) begin
                if (sb.size() == 0) chk("unexpected_output", 32'(dout), 32'hDEAD);
                else begin
                    e = sb.pop_front();
                    chk("dout", 32'(dout), 32'(e.dout));
                    chk("err_mask", 32'(err_mask), 32'(e.err));
                    chk("latency", 32'(cyc - e.acc), 32'(N));
                end
            end
            pv = out_valid;
            out_ready = rr_en ? 1'($urandom_range(0, 1)) : forced_ready;
        end
    end

    initial begin
        logic [4*N-1:0] held;
        int n;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_err", 32'(err_mask), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("idle_rst_in_ready", 32'(in_ready), 32'd1);
        chk("idle_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        send(1'b0, 16'h1234);
        send(1'b1, 16'hC345);
        send(1'b0, 16'h9A09);
        send(1'b1, 16'h0F3D);
        for (int k = 0; k < 40; k++) begin
            logic [4*N-1:0] x;
            x = 16'($urandom);
            if (k % 2 == 0)
                for (int i = 0; i < N; i++) x[4*i +: 4] = 4'($urandom_range(3, 9));
            send(1'($urandom_range(0, 1)), x);
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain", 32'(sb.size()), 32'd0);

        // Back-pressure: hold result in DONE for 5 cycles while in_valid pulses.
        rr_en = 1'b0; forced_ready = 1'b0;
        send(1'b0, 16'h0471);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("stall_reach_done", 32'(out_valid), 32'd1);
        held = dout;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; din = 16'($urandom);
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_dout", 32'(dout), 32'(held));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        forced_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_dout_kept", 32'(dout), 32'(held));
        rr_en = 1'b1;

        // Reset while converting digit 2 aborts the word.
        send(1'b0, 16'h5555);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_dout", 32'(dout), 32'h0);
        chk("abort_err", 32'(err_mask), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        send(1'b0, 16'h0999);
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("after_abort_drain", 32'(sb.size()), 32'd0);
        chk("after_abort_dout", 32'(dout), 32'h3CCC);

        // NDIG=1 sweep over every valid code in both directions.
        for (int m = 0; m < 2; m++) begin
            for (int d = 0; d < 10; d++) begin
                int v, acc;
                v = (m == 0) ? d : d + 3;
                @(negedge clk);
                in_valid1 = 1'b1; mode1 = 1'(m); din1 = 4'(v);
                @(posedge clk); #1;
                acc = cyc;
                in_valid1 = 1'b0;
                n = 0;
                @(negedge clk);
                while (!out_valid1 && n < 10) begin @(negedge clk); n++; end
                chk("n1_latency", 32'(cyc - acc), 32'd1);
                chk("n1_dout", 32'(dout1), (m == 0) ? 32'(v + 3) : 32'(v - 3));
                chk("n1_err", 32'(err_mask1), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
